// File: rtl/qspi_burst_slave.sv
// qspi_burst_slave: SPI / dual / quad register-bus slave, oversampled by main_clock.
// Decodes write (0x02) and read (0x03) commands with burst auto-increment.
//
// Ports:
//   main_clock      in   system clock
//   reset           in   synchronous, active-high reset
//   sck             in   host SPI clock (mode 0)
//   cs              in   chip select, active low
//   io[3:0]         io   data lanes (LANES=1: in io[0], out io[1])
//   addr            out  current word address
//   write_data      out  received word
//   write_data_flag out  one-cycle strobe: write_data/addr valid
//   read_data       in   word supplied by the register map
//   read_data_flag  out  one-cycle strobe: fetch word at addr
//   error_flag      out  one-cycle strobe on an unknown command
module qspi_burst_slave #(
   parameter int unsigned LANES        = 1,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DUMMY_CYCLES = 0
) (
   input  logic                  main_clock,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  cs,
   inout  wire  [3:0]            io,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_data_flag,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_data_flag,
   output logic                  error_flag
);

   localparam int unsigned ShW = (ADDR_WIDTH > DATA_WIDTH) ?
                                 ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) :
                                 ((DATA_WIDTH > 8) ? DATA_WIDTH : 8);

   localparam logic [15:0] CmdLast   = 16'(8 / LANES - 1);
   localparam logic [15:0] AddrLast  = 16'(ADDR_WIDTH / LANES - 1);
   localparam logic [15:0] DataLast  = 16'(DATA_WIDTH / LANES - 1);
   localparam logic [15:0] DummyLast = 16'(DUMMY_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StIgnore
   } state_e;

   // Input synchronisers; deliberately not reset so reset can see the true cs level.
   logic             sck_meta_q, sck_sync_q, sck_prev_q;
   logic             cs_meta_q, cs_sync_q;
   logic [LANES-1:0] io_meta_q, io_sync_q;

   always_ff @(posedge main_clock) begin
      sck_meta_q <= sck;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
      cs_meta_q  <= cs;
      cs_sync_q  <= cs_meta_q;
      io_meta_q  <= io[LANES-1:0];
      io_sync_q  <= io_meta_q;
   end

   logic sck_rise, sck_fall;
   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;

   state_e                state_q;
   logic [15:0]           cnt_q;
   logic [ShW-1:0]        sh_q;
   logic [ShW-1:0]        sh_next;
   logic                  is_read_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wflag_q, rflag_q, eflag_q;
   logic                  fetch_q;
   logic                  inc_q;
   logic [DATA_WIDTH-1:0] tx_q;
   logic [LANES-1:0]      lane_q;
   logic                  oe_q;

   assign sh_next = {sh_q[ShW-LANES-1:0], io_sync_q};

   logic unused_sh;
   assign unused_sh = ^sh_q[ShW-1 -: LANES];

   always_ff @(posedge main_clock) begin
      if (reset) begin
         state_q   <= cs_sync_q ? StIdle : StIgnore;
         cnt_q     <= '0;
         sh_q      <= '0;
         is_read_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wflag_q   <= 1'b0;
         rflag_q   <= 1'b0;
         eflag_q   <= 1'b0;
         fetch_q   <= 1'b0;
         inc_q     <= 1'b0;
         tx_q      <= '0;
         lane_q    <= '0;
         oe_q      <= 1'b0;
      end else begin
         wflag_q <= 1'b0;
         rflag_q <= 1'b0;
         eflag_q <= 1'b0;
         // read_data is captured two cycles after the request strobe
         fetch_q <= rflag_q;
         if (fetch_q) tx_q <= read_data;
         // write address advances the cycle after the write strobe
         if (inc_q) begin
            addr_q <= addr_q + AddrOne;
            inc_q  <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               state_q <= StCmd;
               cnt_q   <= '0;
            end
            StCmd: if (sck_rise) begin
               sh_q  <= sh_next;
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == CmdLast) begin
                  cnt_q <= '0;
                  if (sh_next[7:0] == 8'h02) begin
                     state_q   <= StAddr;
                     is_read_q <= 1'b0;
                  end else if (sh_next[7:0] == 8'h03) begin
                     state_q   <= StAddr;
                     is_read_q <= 1'b1;
                  end else begin
                     state_q <= StIgnore;
                     eflag_q <= 1'b1;
                  end
               end
            end
            StAddr: if (sck_rise) begin
               sh_q  <= sh_next;
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == AddrLast) begin
                  cnt_q  <= '0;
                  addr_q <= sh_next[ADDR_WIDTH-1:0];
                  if (!is_read_q) begin
                     state_q <= StWdata;
                  end else if (DUMMY_CYCLES > 0) begin
                     state_q <= StDummy;
                  end else begin
                     state_q <= StRdata;
                     rflag_q <= 1'b1;
                  end
               end
            end
            StDummy: if (sck_rise) begin
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == DummyLast) begin
                  cnt_q   <= '0;
                  state_q <= StRdata;
                  rflag_q <= 1'b1;
               end
            end
            StWdata: if (sck_rise) begin
               sh_q  <= sh_next;
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == DataLast) begin
                  cnt_q   <= '0;
                  wdata_q <= sh_next[DATA_WIDTH-1:0];
                  wflag_q <= 1'b1;
                  inc_q   <= 1'b1;
               end
            end
            StRdata: begin
               if (sck_fall) begin
                  lane_q <= tx_q[DATA_WIDTH-1 -: LANES];
                  tx_q   <= {tx_q[DATA_WIDTH-LANES-1:0], {LANES{1'b0}}};
                  oe_q   <= 1'b1;
               end
               if (sck_rise) begin
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q == DataLast) begin
                     // prefetch the next burst word while the host samples the last bit
                     cnt_q   <= '0;
                     addr_q  <= addr_q + AddrOne;
                     rflag_q <= 1'b1;
                  end
               end
            end
            StIgnore: ;
            default: state_q <= StIdle;
         endcase

         // Deselect wins over any state transition; a strobe from a coincident
         // last-bit rise above is kept.
         if (cs_sync_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
         end
      end
   end

   logic [3:0] drv_en, drv_val;

   always_comb begin
      drv_en  = '0;
      drv_val = '0;
      if (LANES == 1) begin
         drv_en[1]  = oe_q;
         drv_val[1] = lane_q[0];
      end else begin
         drv_en[LANES-1:0]  = {LANES{oe_q}};
         drv_val[LANES-1:0] = lane_q;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_io
      assign io[i] = drv_en[i] ? drv_val[i] : 1'bz;
   end

   assign addr            = addr_q;
   assign write_data      = wdata_q;
   assign write_data_flag = wflag_q;
   assign read_data_flag  = rflag_q;
   assign error_flag      = eflag_q;

endmodule
